counter_cmd_ctrl: RTL and testbench

- Command controller that sequences the team's loadable up/down counter.
- Two requesters submit commands (LOAD, count UP N steps, count DOWN N steps, READ) over valid/ready handshakes.
- Round-robin arbitration; the winner's command is executed on the counter; the final counter value is returned on a done channel with backpressure.
- Sits between the requesting logic and the counter; it is the only driver of the counter's control pins.

---
 rtl/counter_cmd_ctrl_if.sv | 37 +++
 rtl/counter_cmd_ctrl.sv | 128 ++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_ctrl_if.sv
// rtl/counter_cmd_ctrl_if.sv - requester command channels and done channel for counter_cmd_ctrl
interface counter_cmd_ctrl_if #(
  parameter int DW = 4,
  parameter int NW = 4,
  parameter int AW = (DW > NW) ? DW : NW
);
  logic          req0_valid;
  logic          req0_ready;
  logic [1:0]    req0_op;
  logic [AW-1:0] req0_arg;

  logic          req1_valid;
  logic          req1_ready;
  logic [1:0]    req1_op;
  logic [AW-1:0] req1_arg;

  logic          done_valid;
  logic          done_ready;
  logic          done_id;
  logic [DW-1:0] done_value;

  modport master (
    output req0_valid, req0_op, req0_arg,
    output req1_valid, req1_op, req1_arg,
    output done_ready,
    input  req0_ready, req1_ready,
    input  done_valid, done_id, done_value
  );

  modport slave (
    input  req0_valid, req0_op, req0_arg,
    input  req1_valid, req1_op, req1_arg,
    input  done_ready,
    output req0_ready, req1_ready,
    output done_valid, done_id, done_value
  );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - round-robin command sequencer for the loadable up/down counter
module counter_cmd_ctrl #(
  parameter int DW = 4,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  counter_cmd_ctrl_if.slave bus,
  output logic          cnt_load,
  output logic          cnt_en,
  output logic          cnt_up_down,
  output logic [DW-1:0] cnt_data_in,
  input  logic [DW-1:0] cnt_data_out
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic          last_grant;   // requester granted most recently
  logic [1:0]    op_q;
  logic          id_q;
  logic [NW-1:0] rem_q;
  logic          done_valid_q;
  logic          done_id_q;

  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [1:0]    sel_op;
  logic [DW-1:0] sel_load;
  logic [NW-1:0] sel_steps;

  // Round-robin pick among valid requesters and mux of the winner's command
  always_comb begin
    grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1    = bus.req1_valid && !grant0;
    accept    = rstn && (state == IDLE) && (grant0 || grant1);
    sel_op    = grant1 ? bus.req1_op : bus.req0_op;
    sel_load  = grant1 ? bus.req1_arg[DW-1:0] : bus.req0_arg[DW-1:0];
    sel_steps = grant1 ? bus.req1_arg[NW-1:0] : bus.req0_arg[NW-1:0];
  end

  // Ready is only offered in IDLE and is held low while reset is asserted
  assign bus.req0_ready = rstn && (state == IDLE) && grant0;
  assign bus.req1_ready = rstn && (state == IDLE) && grant1;

  // The counter is idle in RESP, so its live value is the stable result
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_value = done_valid_q ? cnt_data_out : '0;

  // Command FSM with registered counter controls and done flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_q         <= OP_LOAD;
      id_q         <= 1'b0;
      rem_q        <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_en       <= 1'b0;
      cnt_up_down  <= 1'b0;
      cnt_data_in  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            id_q       <= grant1;
            last_grant <= grant1;
            rem_q      <= sel_steps;
            case (sel_op)
              OP_LOAD: begin
                cnt_load    <= 1'b1;
                cnt_data_in <= sel_load;
                state       <= EXEC;
              end
              OP_UP, OP_DOWN: begin
                if (sel_steps == '0) begin
                  done_valid_q <= 1'b1;
                  done_id_q    <= grant1;
                  state        <= RESP;
                end else begin
                  cnt_en      <= 1'b1;
                  cnt_up_down <= (sel_op == OP_UP);
                  state       <= EXEC;
                end
              end
              default: begin
                done_valid_q <= 1'b1;
                done_id_q    <= grant1;
                state        <= RESP;
              end
            endcase
          end
        end
        EXEC: begin
          // LOAD takes one cycle; UP/DOWN runs until the last step is issued
          if (op_q == OP_LOAD || rem_q == NW'(1)) begin
            cnt_load     <= 1'b0;
            cnt_en       <= 1'b0;
            done_valid_q <= 1'b1;
            done_id_q    <= id_q;
            state        <= RESP;
          end
          if (op_q != OP_LOAD) begin
            rem_q <= rem_q - NW'(1);
          end
        end
        RESP: begin
          if (bus.done_ready) begin
            done_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb/tb_counter_cmd_ctrl.sv - directed self-checking bench for counter_cmd_ctrl
module tb_counter_cmd_ctrl;
  localparam int DW = 4;
  localparam int NW = 4;

  logic          clk;
  logic          rstn;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_up_down;
  logic [DW-1:0] cnt_data_in;
  logic [DW-1:0] cnt_q;

  int n_vec = 0;
  int n_err = 0;

  counter_cmd_ctrl_if #(.DW(DW), .NW(NW)) bus ();

  counter_cmd_ctrl #(.DW(DW), .NW(NW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .cnt_load     (cnt_load),
    .cnt_en       (cnt_en),
    .cnt_up_down  (cnt_up_down),
    .cnt_data_in  (cnt_data_in),
    .cnt_data_out (cnt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference loadable up/down counter driven by the controller
  initial cnt_q = '0;
  always_ff @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_data_in;
    else if (cnt_en) cnt_q <= cnt_up_down ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.req0_ready, bus.req1_ready, bus.done_valid, bus.done_id,
            bus.done_value, cnt_load, cnt_en, cnt_up_down, cnt_data_in};
  endfunction

  function automatic logic [31:0] done_tuple();
    return {bus.done_valid, bus.done_id, bus.done_value};
  endfunction

  initial begin
    rstn = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 2'($urandom_range(0, 3));
    bus.req0_arg   = 4'($urandom);
    bus.req1_valid = 1'b1;
    bus.req1_op    = 2'($urandom_range(0, 3));
    bus.req1_arg   = 4'($urandom);
    bus.done_ready = 1'($urandom);
    tick();
    tick();
    settle();
    chk("reset_outputs", all_outs(), 32'h0);

    // release reset, both valid: requester 0 wins the first tie
    rstn = 1'b1;
    bus.req0_op = 2'b00; bus.req0_arg = 4'd9;
    bus.req1_op = 2'b01; bus.req1_arg = 4'd3;
    bus.done_ready = 1'b1;
    settle();
    chk("first_tie_grant", {bus.req0_ready, bus.req1_ready}, 32'b10);

    // LOAD 9 from requester 0
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    settle();
    chk("load9_exec", {cnt_load, cnt_en, cnt_data_in, bus.done_valid}, {1'b1, 1'b0, 4'd9, 1'b0});
    tick();
    chk("load9_done", {cnt_load, done_tuple()}, {1'b0, 1'b1, 1'b0, 4'd9});
    tick();
    chk("load9_idle", bus.done_valid, 1'b0);

    // LOAD 14 from requester 0 alone
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_arg = 4'd14;
    settle();
    chk("load14_ready", {bus.req0_ready, bus.req1_ready}, 32'b10);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("load14_done", done_tuple(), {1'b1, 1'b0, 4'd14});
    tick();

    // UP 3 from requester 1 wraps 14 -> 1
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_arg = 4'd3;
    settle();
    chk("up3_ready", {bus.req0_ready, bus.req1_ready}, 32'b01);
    tick();
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("up3_step%0d", i), {cnt_en, cnt_up_down, cnt_load, bus.done_valid}, 4'b1100);
      tick();
    end
    chk("up3_done", {cnt_en, done_tuple()}, {1'b0, 1'b1, 1'b1, 4'd1});
    tick();

    // Both requesters issue DOWN 1 continuously: grants alternate
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_arg = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_arg = 4'd1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("arb%0d_grant", k), {bus.req0_ready, bus.req1_ready},
          (k % 2 == 0) ? 32'b10 : 32'b01);
      tick();
      chk($sformatf("arb%0d_exec", k), {cnt_en, cnt_up_down}, 2'b10);
      tick();
      chk($sformatf("arb%0d_done", k), done_tuple(),
          {1'b1, 1'(k % 2), 4'(4'd1 - 4'(k + 1))});
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // DOWN 0 from requester 0 goes straight to the response
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_arg = 4'd0;
    settle();
    chk("down0_ready", {bus.req0_ready, bus.req1_ready}, 32'b10);
    tick();
    bus.req0_valid = 1'b0;
    chk("down0_done", {cnt_en, done_tuple()}, {1'b0, 1'b1, 1'b0, 4'd13});
    tick();

    // READ from requester 1
    bus.req1_valid = 1'b1; bus.req1_op = 2'b11; bus.req1_arg = 4'd7;
    settle();
    chk("read_ready", {bus.req0_ready, bus.req1_ready}, 32'b01);
    tick();
    bus.req1_valid = 1'b0;
    chk("read_done", {cnt_en, cnt_load, done_tuple()}, {1'b0, 1'b0, 1'b1, 1'b1, 4'd13});
    tick();

    // Backpressure: response held for 5 cycles while requester 1 waits
    bus.done_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b11;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_arg = 4'd10;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("bp_hold%0d", i), {bus.req0_ready, bus.req1_ready, done_tuple()},
          {1'b0, 1'b0, 1'b1, 1'b0, 4'd13});
      tick();
    end
    bus.done_ready = 1'b1;
    tick();
    chk("bp_released", {bus.done_valid, bus.req1_ready}, 2'b01);

    // UP 10 interrupted by reset during the 4th step
    tick();
    bus.req1_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("up10_step4", {cnt_en, cnt_up_down}, 2'b11);
    rstn = 1'b0;
    settle();
    chk("midexec_reset", all_outs(), 32'h0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no_done%0d", i), {bus.done_valid, cnt_en}, 2'b00);
    end

    // Controller back in IDLE: READ shows only 3 steps were applied (13 -> 0)
    bus.req0_valid = 1'b1; bus.req0_op = 2'b11;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b11;
    settle();
    chk("post_reset_grant", {bus.req0_ready, bus.req1_ready}, 32'b10);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("post_reset_read", done_tuple(), {1'b1, 1'b0, 4'd0});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
